// File: rtl/l1a_match_fifo.sv
// l1a_match_fifo: pairs each L1A with its delayed L1A_MATCH result, tags it
// with a running L1A number and buffers {match, number} in a FWFT FIFO.
// Optional build macro: L1A_MATCH_FILTER_EN (store only matched entries).
// Ports:
//   CLK, RST_N      clock, synchronous active-low reset
//   L1A, L1A_MATCH  accept strobe and its match result (L1FD+1 clocks later)
//   L1FD            fine delay, static between resets
//   RD_EN           pop request, honoured only while VALID
//   DOUT            head entry {match, number}; 0 while empty
//   VALID/FULL      not-empty / full flags
//   COUNT           occupancy 0..2^ADDR_W
//   OVERFLOW        sticky: entry dropped on full FIFO
//   ORPHAN          sticky: match pulse without an aligned L1A
module l1a_match_fifo #(
    parameter int ADDR_W = 4,
    parameter int NUM_W  = 12
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              L1A,
    input  logic              L1A_MATCH,
    input  logic [3:0]        L1FD,
    input  logic              RD_EN,
    output logic [NUM_W:0]    DOUT,
    output logic              VALID,
    output logic              FULL,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW,
    output logic              ORPHAN
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0]       aln_sr;
    logic              aln;
    logic [NUM_W-1:0]  num;
    logic [NUM_W:0]    mem [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic              empty;
    logic              full;
    logic              keep;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              drop;
    logic [NUM_W:0]    entry;

    // Tap k of the line is L1A delayed k+1 clocks, matching the delay stage.
    assign aln   = aln_sr[L1FD];
    assign entry = {L1A_MATCH, num};

`ifdef L1A_MATCH_FILTER_EN
    assign keep = L1A_MATCH;
`else
    assign keep = 1'b1;
`endif

    assign empty = (wptr == rptr);
    // Same index, different lap bit: the writer is a full lap ahead.
    assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

    assign pop      = RD_EN && !empty;
    assign push_req = aln && keep;
    // A pop in the same cycle frees the slot the push needs.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            aln_sr   <= '0;
            num      <= '0;
            wptr     <= '0;
            rptr     <= '0;
            OVERFLOW <= 1'b0;
            ORPHAN   <= 1'b0;
        end else begin
            aln_sr <= {aln_sr[14:0], L1A};
            if (aln)
                num <= num + 1'b1;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (drop)
                OVERFLOW <= 1'b1;
            if (L1A_MATCH && !aln)
                ORPHAN <= 1'b1;
        end
    end

    // Storage needs no reset: DOUT is gated by VALID.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wptr[ADDR_W-1:0]] <= entry;
    end

    assign VALID = !empty;
    assign FULL  = full;
    assign COUNT = wptr - rptr;
    assign DOUT  = empty ? '0 : mem[rptr[ADDR_W-1:0]];

endmodule

// File: tb/tb_l1a_match_fifo.sv
// Scoreboard bench for l1a_match_fifo.
// Expected entries are queued at alignment time and compared on pop.
module tb_l1a_match_fifo;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        L1A = 1'b0;
    logic        L1A_MATCH = 1'b0;
    logic [3:0]  L1FD = 4'd0;
    logic        RD_EN = 1'b0;
    logic [12:0] DOUT;
    logic        VALID;
    logic        FULL;
    logic [4:0]  COUNT;
    logic        OVERFLOW;
    logic        ORPHAN;

    int total = 0;
    int bad = 0;

    logic [12:0] q[$];
    logic [15:0] hist;
    logic [11:0] mnum;
    logic        movf;
    logic        morph;

    l1a_match_fifo dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .L1A(L1A),
        .L1A_MATCH(L1A_MATCH),
        .L1FD(L1FD),
        .RD_EN(RD_EN),
        .DOUT(DOUT),
        .VALID(VALID),
        .FULL(FULL),
        .COUNT(COUNT),
        .OVERFLOW(OVERFLOW),
        .ORPHAN(ORPHAN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(COUNT), 32'(q.size()));
        chk("valid", 32'(VALID), 32'(q.size() != 0));
        chk("full", 32'(FULL), 32'(q.size() == DEPTH));
        chk("ovf", 32'(OVERFLOW), 32'(movf));
        chk("orph", 32'(ORPHAN), 32'(morph));
        if (q.size() != 0)
            chk("head", 32'(DOUT), 32'(q[0]));
    endtask

    // One clock: drive, predict, clock, compare.
    task automatic step(input logic l1a, input logic m, input logic rd);
        logic        aln;
        logic        keep;
        logic        pop;
        logic        preq;
        logic [12:0] e;
        L1A = l1a;
        L1A_MATCH = m;
        RD_EN = rd;
        aln = hist[L1FD];
`ifdef L1A_MATCH_FILTER_EN
        keep = m;
`else
        keep = 1'b1;
`endif
        pop = rd && (q.size() != 0);
        preq = aln && keep;
        e = {m, mnum};
        if (pop)
            chk("pop_head", 32'(DOUT), 32'(q[0]));
        @(posedge CLK);
        #1;
        if (preq && q.size() == DEPTH && !pop)
            movf = 1'b1;
        if (m && !aln)
            morph = 1'b1;
        if (pop)
            void'(q.pop_front());
        if (preq && q.size() < DEPTH)
            q.push_back(e);
        if (aln)
            mnum = mnum + 12'd1;
        hist = {hist[14:0], l1a};
        check_all();
    endtask

    task automatic do_reset(input logic [3:0] fd, input logic l1a);
        RST_N = 1'b0;
        L1A = l1a;
        L1A_MATCH = 1'b0;
        RD_EN = 1'b0;
        @(posedge CLK);
        #1;
        L1FD = fd;
        q.delete();
        hist = '0;
        mnum = '0;
        movf = 1'b0;
        morph = 1'b0;
        RST_N = 1'b1;
        L1A = 1'b0;
        chk("rst_dout", 32'(DOUT), 32'd0);
        check_all();
    endtask

    initial begin
        hist = '0;
        mnum = '0;
        movf = 1'b0;
        morph = 1'b0;

        // L1FD=0: single matched L1A, then pop it
        do_reset(4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // L1FD=9: two L1As, only the second one matched
        do_reset(4'd9, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 2; i <= 11; i++)
            step(1'b0, i == 11, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Fill, push+pop on full, then overflow and drain
        do_reset(4'd0, 1'b0);
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++)
            step(1'b0, 1'b0, 1'b1);

        // Orphan match pulse
        do_reset(4'd2, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Number wrap with continuous reads
        do_reset(4'd0, 1'b0);
        for (int i = 0; i < 4100; i++)
            step(i < 4097, i[0], 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Reset with 3 stored and one in flight
        do_reset(4'd5, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        do_reset(4'd5, 1'b0);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Random traffic, aligned matches only
        do_reset(4'd3, 1'b0);
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), hist[L1FD] && 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1a_match_fifo.md
# l1a_match_fifo

Downstream consumer of the LCT delay/match stage. Pairs every L1A with the L1A_MATCH result that the delay stage produces L1FD+1 clocks later. Tags each L1A with a running L1A number and buffers {match, number} entries in a first-word-fall-through FIFO for readout control. Flags buffer overflow and match pulses that do not line up with any L1A.

## Interface
Parameters:
- ADDR_W, 4: FIFO address width; depth = 2^ADDR_W entries.
- NUM_W, 12: L1A number width; wraps modulo 2^NUM_W.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- L1A  in  1  level-1 accept strobe, one clock wide per L1A.
- L1A_MATCH  in  1  match result from the delay stage; valid L1FD+1 clocks after its L1A.
- L1FD  in  4  L1A fine delay, same value driven to the delay stage; static between resets.
- RD_EN  in  1  pop request; acts only when VALID=1.
- DOUT  out  NUM_W+1  head entry: bit NUM_W = match flag, bits NUM_W-1:0 = L1A number.
- VALID  out  1  FIFO not empty; DOUT holds the head entry.
- FULL  out  1  occupancy = 2^ADDR_W.
- COUNT  out  ADDR_W+1  occupancy, 0..2^ADDR_W.
- OVERFLOW  out  1  sticky: an entry was dropped because the FIFO was full.
- ORPHAN  out  1  sticky: L1A_MATCH was high with no aligned L1A.

## Operation
- Alignment line: 16-stage shift register on L1A. The tap at L1FD gives the aligned strobe ALN, delayed L1FD+1 clocks from L1A. This is the same delay the match logic applies.
- On ALN=1:
  - form entry {L1A_MATCH, num}.
  - num = count of earlier ALN strobes since reset, modulo 2^NUM_W; the first L1A after reset gets 0.
  - num increments on every ALN, whether or not the entry is stored or dropped.
- L1A_MATCH=1 with ALN=0: sets ORPHAN. No entry is pushed.
- Push occurs when ALN=1, the entry passes the filter (see Configuration), and either FULL=0 or a pop happens in the same cycle.
- Dropped push (FULL=1, no pop): sets OVERFLOW; the entry is lost.
- Pop: VALID=1 and RD_EN=1. The head advances and DOUT shows the next entry on the following cycle. RD_EN with VALID=0 is ignored.
- Push and pop in the same cycle:
  - FIFO empty: only the push takes effect (the pop is ignored).
  - FIFO full: both succeed; COUNT stays 2^ADDR_W and OVERFLOW is not set.
  - Otherwise: both succeed and COUNT is unchanged.
- Pointers are ADDR_W+1 bits and wrap naturally. Full/empty come from pointer MSB comparison.
- OVERFLOW and ORPHAN clear only on reset.
- Reset, including mid-operation, clears in the same cycle:
  - alignment line, num, and pointers;
  - outputs: DOUT=0, VALID=0, FULL=0, COUNT=0, OVERFLOW=0, ORPHAN=0.
  - Any L1A still in flight in the alignment line is discarded.
- Changing L1FD without a reset gives undefined pairing. The bench must not check this case.

## Timing
- L1A at cycle t: ALN is asserted at t+L1FD+1, and L1A_MATCH is sampled in that same cycle.
- The entry is visible on DOUT with VALID=1 at t+L1FD+2 if the FIFO was empty. This is first-word fall-through with a registered output.
- COUNT, FULL and VALID update one clock after the push/pop edge.
- OVERFLOW and ORPHAN assert one clock after the offending cycle.
- Back-to-back L1As on consecutive clocks are supported: one entry per clock.
- Throughput: one push and one pop per clock.

## Configuration
- L1A_MATCH_FILTER_EN defined: only entries with match flag=1 are pushed. Unmatched L1As still consume an L1A number.
- L1A_MATCH_FILTER_EN undefined: every aligned L1A is pushed, matched or not.

## Test plan
- L1FD=0, single L1A at t, L1A_MATCH=1 at t+1 -> VALID at t+2, DOUT={1,0x000}; RD_EN -> VALID=0 next clock.
- L1FD=9, L1As at t and t+1, L1A_MATCH high only at t+11 -> entries {0,0x000} then {1,0x001}; COUNT=2.
- 17 L1As with no reads, default depth, filter undefined -> FULL=1, COUNT=16, OVERFLOW=1; popping all 16 yields numbers 0..15.
- FIFO full while a push and a pop occur in the same cycle -> COUNT stays 16, OVERFLOW stays 0, and the new entry lands at the tail.
- L1A_MATCH pulse with no L1A L1FD+1 clocks earlier -> ORPHAN=1 and COUNT unchanged. A separate sub-case: 4096 L1As wrap num to 0x000. With L1A_MATCH_FILTER_EN, unmatched L1As leave COUNT=0.
- RST_N low for one clock while an L1A is in flight and 3 entries are stored -> all outputs 0; the in-flight L1A is never pushed; the next L1A gets num 0x000.
